// File: rtl/imem_pkg.sv
// ============================================================================
// Module      : imem_pkg
// Description : Shared types and constants for the instruction-memory port
//               arbiter and the PC logic. Holds the arbiter state encoding,
//               the default RAM index width, the NOP word and the fixed
//               reset/exception vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_pkg;

  // Default RAM word-index width (depth = 2**AW_DEF words).
  localparam int unsigned AW_DEF = 8;

  // Instruction word presented on fetch_inst at reset and after a restart.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Vectors shared with the PC logic.
  localparam logic [31:0] RESET_VECTOR       = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_ILLEGAL = 32'h0000_0004;
  localparam logic [31:0] EXC_VECTOR_IRQ     = 32'h0000_0008;

  // Port-ownership state machine.
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_LOAD    = 2'd2,
    ST_RESTART = 2'd3
  } arb_state_e;

  // A loader byte address is usable only if it is word aligned and falls
  // inside the RAM: every bit above the word index must be zero.
  function automatic logic load_addr_ok(input logic [31:0] addr,
                                        input int unsigned aw);
    logic [31:0] w_limit;
    w_limit = 32'd1 << (aw + 32'd2);
    return (addr < w_limit) && (addr[1:0] == 2'b00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_sync_ram.sv
// ============================================================================
// Module      : imem_sync_ram
// Description : Single-port 2**AW x 32 synchronous RAM with a registered read
//               (1-cycle latency, read-before-write). Contents are never
//               touched by reset. Instantiated at system level next to the
//               imem_load_arbiter, which drives its port.
// Ports       : clk   - clock
//               we    - write enable
//               addr  - word index
//               wdata - write data
//               rdata - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_sync_ram
  import imem_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule

`default_nettype wire

// File: rtl/imem_load_arbiter.sv
// ============================================================================
// Module      : imem_load_arbiter
// Description : Owns the single port of the instruction RAM and shares it
//               between CPU instruction fetch and a program loader.
//               RUN serves fetches; a loader request holds the CPU, drains
//               the in-flight read, grants the loader write access, then
//               pulses cpu_restart so the PC re-enters the reset vector.
// Ports       : clk, reset            - clock, async active-high reset
//               fetch_req/addr        - CPU fetch request and byte address
//               fetch_inst/valid      - returned instruction, 1 cycle later
//               cpu_hold/cpu_restart  - pipeline freeze / restart pulse
//               load_req/grant        - loader ownership handshake
//               load_we/addr/data     - loader write strobe, address, data
//               load_count/load_err   - session word count / sticky error
//               mem_addr/we/wdata     - RAM port drive
//               mem_rdata             - RAM registered read data
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_load_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned AW  = AW_DEF,
  parameter logic [31:0] NOP = NOP_WORD
) (
  input  logic          clk,
  input  logic          reset,
  // CPU fetch side
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic [31:0]   fetch_inst,
  output logic          fetch_valid,
  output logic          cpu_hold,
  output logic          cpu_restart,
  // Loader side
  input  logic          load_req,
  output logic          load_grant,
  input  logic          load_we,
  input  logic [31:0]   load_addr,
  input  logic [31:0]   load_data,
  output logic [AW:0]   load_count,
  output logic          load_err,
  // RAM port
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [AW:0] COUNT_MAX = {1'b1, {AW{1'b0}}};

  arb_state_e  r_state;
  arb_state_e  w_next_state;

  logic        r_fetch_valid;
  logic [31:0] r_inst_hold;
  logic [AW:0] r_load_count;
  logic        r_load_err;

  logic        w_addr_ok;
  logic        w_write_fire;
  logic        w_write_ok;
  logic        w_session_start;

  // Fetch address bits outside the word index are deliberately ignored:
  // addresses beyond the RAM alias onto it by truncation.
  logic        w_unused_fetch_bits;
  assign w_unused_fetch_bits = ^{fetch_addr[31:AW+2], fetch_addr[1:0]};

  assign w_addr_ok       = load_addr_ok(load_addr, AW);
  assign w_write_fire    = (r_state == ST_LOAD) && load_we;
  assign w_write_ok      = w_write_fire && w_addr_ok;
  assign w_session_start = (r_state == ST_RUN) && load_req;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RUN:     if (load_req)  w_next_state = ST_DRAIN;
      ST_DRAIN:                  w_next_state = ST_LOAD;
      ST_LOAD:    if (!load_req) w_next_state = ST_RESTART;
      ST_RESTART:                w_next_state = ST_RUN;
      default:                   w_next_state = ST_RUN;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. The loader write path is a same-cycle pass-through so the
  // loader sees no extra latency; the RAM port follows fetch_addr otherwise.
  // --------------------------------------------------------------------------
  always_comb begin
    cpu_hold    = 1'b1;
    cpu_restart = 1'b0;
    load_grant  = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = fetch_addr[AW+1:2];
    mem_wdata   = load_data;
    case (r_state)
      ST_RUN: begin
        cpu_hold = 1'b0;
      end
      ST_DRAIN: begin
        cpu_hold = 1'b1;
      end
      ST_LOAD: begin
        load_grant = 1'b1;
        mem_addr   = load_addr[AW+1:2];
        mem_we     = w_write_ok;
      end
      ST_RESTART: begin
        cpu_restart = 1'b1;
      end
      default: begin
        cpu_hold = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Fetch return path. Only RUN accepts fetches, so a read accepted in the
  // last RUN cycle returns during DRAIN and nothing is in flight in LOAD.
  // The RAM read data is already registered, so it is forwarded directly in
  // the valid cycle and captured into r_inst_hold to keep fetch_inst stable.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_valid <= 1'b0;
      r_inst_hold   <= NOP;
    end else begin
      r_fetch_valid <= (r_state == ST_RUN) && fetch_req;
      if (r_state == ST_RESTART) begin
        r_inst_hold <= NOP;
      end else if (r_fetch_valid) begin
        r_inst_hold <= mem_rdata;
      end
    end
  end

  assign fetch_valid = r_fetch_valid;
  assign fetch_inst  = r_fetch_valid ? mem_rdata : r_inst_hold;

  // --------------------------------------------------------------------------
  // Loader session statistics. Cleared when a new session begins (RUN->DRAIN)
  // and otherwise retained so the last session's result stays readable.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load_count <= '0;
      r_load_err   <= 1'b0;
    end else if (w_session_start) begin
      r_load_count <= '0;
      r_load_err   <= 1'b0;
    end else if (w_write_fire) begin
      if (!w_addr_ok) begin
        r_load_err <= 1'b1;
      end else if (r_load_count != COUNT_MAX) begin
        r_load_count <= r_load_count + 1'b1;
      end
    end
  end

  assign load_count = r_load_count;
  assign load_err   = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_imem_load_arbiter.sv
// ============================================================================
// Module      : tb_imem_load_arbiter
// Description : Self-checking bench for imem_load_arbiter with the RAM
//               attached. A shadow image tracks accepted loader writes;
//               fetch expectations are queued with their due cycle and
//               compared when fetch_valid is seen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_load_arbiter;
  import imem_pkg::*;

  localparam int unsigned AW = 8;

  logic          clk;
  logic          rst;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic [31:0]   fetch_inst;
  logic          fetch_valid;
  logic          cpu_hold;
  logic          cpu_restart;
  logic          load_req;
  logic          load_grant;
  logic          load_we;
  logic [31:0]   load_addr;
  logic [31:0]   load_data;
  logic [AW:0]   load_count;
  logic          load_err;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  imem_load_arbiter #(.AW(AW), .NOP(32'h0000_0000)) u_dut (
    .clk         (clk),
    .reset       (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_inst  (fetch_inst),
    .fetch_valid (fetch_valid),
    .cpu_hold    (cpu_hold),
    .cpu_restart (cpu_restart),
    .load_req    (load_req),
    .load_grant  (load_grant),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_count  (load_count),
    .load_err    (load_err),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  imem_sync_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] data;
  } fetch_exp_t;

  fetch_exp_t  sb_q[$];
  logic [31:0] shadow [256];
  int          exp_count;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: runs on the falling edge, away from input changes.
  always @(negedge clk) begin
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      chk("fetch_valid", {63'd0, fetch_valid}, 64'd1);
      chk("fetch_inst", {32'd0, fetch_inst}, {32'd0, sb_q[0].data});
      void'(sb_q.pop_front());
    end else if (fetch_valid) begin
      chk("spurious_valid", {63'd0, fetch_valid}, 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a fetch that the arbiter is expected to accept at the next edge.
  task automatic fetch_issue(input logic [31:0] addr);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    sb_q.push_back('{due: cyc + 1, data: shadow[addr[9:2]]});
    #1;
    chk("run_mem_addr", {56'd0, mem_addr}, {56'd0, addr[9:2]});
  endtask

  task automatic drive_write(input logic [31:0] addr, input logic [31:0] data);
    logic ok;
    ok        = (addr < 32'h400) && (addr[1:0] == 2'b00);
    load_we   = 1'b1;
    load_addr = addr;
    load_data = data;
    #1;
    chk("load_mem_we", {63'd0, mem_we}, {63'd0, ok});
    if (ok) begin
      chk("load_mem_addr", {56'd0, mem_addr}, {56'd0, addr[9:2]});
      chk("load_mem_wdata", {32'd0, mem_wdata}, {32'd0, data});
      shadow[addr[9:2]] = data;
      if (exp_count < 256) exp_count++;
    end
  endtask

  task automatic write(input logic [31:0] addr, input logic [31:0] data);
    drive_write(addr, data);
    tick();
    load_we = 1'b0;
  endtask

  task automatic start_session();
    load_req = 1'b1;
    tick();
    chk("drain_hold", {63'd0, cpu_hold}, 64'd1);
    chk("drain_grant", {63'd0, load_grant}, 64'd0);
    chk("drain_count_clr", {55'd0, load_count}, 64'd0);
    chk("drain_err_clr", {63'd0, load_err}, 64'd0);
    tick();
    fetch_req = 1'b0;
    chk("load_grant", {63'd0, load_grant}, 64'd1);
    chk("load_hold", {63'd0, cpu_hold}, 64'd1);
    exp_count = 0;
  endtask

  // Drop load_req; the caller may have a final write already driven.
  task automatic end_session();
    load_req = 1'b0;
    tick();
    load_we = 1'b0;
    chk("restart_pulse", {63'd0, cpu_restart}, 64'd1);
    chk("restart_hold", {63'd0, cpu_hold}, 64'd1);
    chk("restart_grant", {63'd0, load_grant}, 64'd0);
    chk("session_count", {55'd0, load_count}, 64'(exp_count));
    tick();
    chk("run_restart_low", {63'd0, cpu_restart}, 64'd0);
    chk("run_hold_low", {63'd0, cpu_hold}, 64'd0);
    chk("nop_after_restart", {32'd0, fetch_inst}, 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    load_req   = 1'b0;
    load_we    = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    exp_count  = 0;
    for (int i = 0; i < 256; i++) shadow[i] = '0;

    // Reset values
    tick();
    tick();
    chk("rst_fetch_valid", {63'd0, fetch_valid}, 64'd0);
    chk("rst_fetch_inst", {32'd0, fetch_inst}, 64'd0);
    chk("rst_hold", {63'd0, cpu_hold}, 64'd0);
    chk("rst_restart", {63'd0, cpu_restart}, 64'd0);
    chk("rst_grant", {63'd0, load_grant}, 64'd0);
    chk("rst_count", {55'd0, load_count}, 64'd0);
    chk("rst_err", {63'd0, load_err}, 64'd0);
    chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
    rst = 1'b0;
    tick();

    // Fill the whole RAM plus one extra write: count saturates at 256.
    start_session();
    for (int i = 0; i < 257; i++) begin
      write(32'((i % 256) * 4), 32'hC0DE_0000 ^ (32'(i % 256) * 32'h0001_0101));
    end
    chk("count_saturate", {55'd0, load_count}, 64'd256);
    end_session();
    chk("count_kept", {55'd0, load_count}, 64'd256);

    // Back-to-back fetches, plus an aliased address beyond the RAM.
    fetch_issue(32'h0000_000C);
    tick();
    fetch_issue(32'h0000_0010);
    tick();
    fetch_issue(32'h0000_040C);
    tick();
    fetch_req = 1'b0;
    tick();
    tick();

    // Two-word load session; last write coincides with load_req dropping.
    start_session();
    write(32'h0000_000C, 32'h2004_0003);
    drive_write(32'h0000_0010, 32'h1000_FFFF);
    end_session();
    fetch_issue(32'h0000_000C);
    tick();
    fetch_req = 1'b0;
    tick();

    // Collision: fetch and load_req together; fetch held into DRAIN.
    fetch_issue(32'h0000_0010);
    start_session();
    // Bad writes: out of range and misaligned.
    drive_write(32'h0000_0400, 32'hBAD0_0001);
    tick();
    drive_write(32'h0000_000E, 32'hBAD0_0002);
    tick();
    load_we = 1'b0;
    chk("err_set", {63'd0, load_err}, 64'd1);
    chk("err_count_same", {55'd0, load_count}, 64'd0);
    write(32'h0000_0014, 32'h0BAD_F00D);
    chk("err_sticky", {63'd0, load_err}, 64'd1);
    end_session();
    // New session clears the error flag on DRAIN entry (checked inside).
    start_session();
    end_session();

    // load_we outside LOAD is ignored.
    load_we   = 1'b1;
    load_addr = 32'h0000_000C;
    load_data = 32'hDEAD_BEEF;
    #1;
    chk("run_we_ignored", {63'd0, mem_we}, 64'd0);
    tick();
    load_we = 1'b0;
    chk("run_we_no_err", {63'd0, load_err}, 64'd0);
    fetch_issue(32'h0000_000C);
    tick();
    fetch_issue(32'h0000_0014);
    tick();
    fetch_req = 1'b0;
    tick();

    // Reset in the middle of LOAD after three writes.
    start_session();
    write(32'h0000_0050, 32'h1111_0050);
    write(32'h0000_0054, 32'h2222_0054);
    write(32'h0000_0058, 32'h3333_0058);
    rst      = 1'b1;
    load_req = 1'b0;
    #1;
    chk("midrst_grant", {63'd0, load_grant}, 64'd0);
    chk("midrst_hold", {63'd0, cpu_hold}, 64'd0);
    chk("midrst_count", {55'd0, load_count}, 64'd0);
    chk("midrst_restart", {63'd0, cpu_restart}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_no_restart", {63'd0, cpu_restart}, 64'd0);
    fetch_issue(32'h0000_0050);
    tick();
    fetch_issue(32'h0000_0054);
    tick();
    fetch_issue(32'h0000_0058);
    tick();
    fetch_req = 1'b0;
    tick();
    tick();

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
